mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Parametrised multicycle multiply/divide unit driving the HI/LO pair of the multicycle MIPS datapath; the generalised successor to the fixed-width mult/div paths.
- Performs MULT, MULTU, DIV and DIVU on operands from registers A/B using a start/busy/done handshake.
- Adds a divide-by-zero flag for the exception path.
- Results land in internal HI/LO registers that feed the register-write data mux.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low; reset==0 sampled at a rising edge clears all state.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with start.
- a  input  WIDTH  multiplicand / dividend; captured with start.
- b  input  WIDTH  multiplier / divisor; captured with start.
- busy  output  1  high while an operation is in progress, including the done cycle.
- done  output  1  one-cycle pulse; HI/LO are valid in this cycle.
- div_zero  output  1  one-cycle pulse coincident with done when DIV/DIVU has b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
Reset:
- On reset==0: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and working registers cleared.
- Applies mid-operation: the operation is abandoned and no done is produced.

State machine IDLE -> CALC -> FIX -> DONE -> IDLE:
- IDLE: on start=1, capture op/a/b.
  - Signed ops take absolute values of the operands and record the result signs: product sign = a[W-1]^b[W-1]; quotient sign likewise; remainder sign = a[W-1].
  - Load counter=WIDTH and go to CALC.
  - Exception: DIV/DIVU with b==0 go directly to DONE with the zero flag set.
- CALC, multiply: radix-2 shift-add over a 2*WIDTH accumulator, one bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- CALC exit: counter decrements each cycle; leave CALC when it reaches 1 after that iteration, so CALC lasts exactly WIDTH cycles.
- FIX: apply two's-complement negation per the recorded signs; register the results into hi/lo.
  - Multiply: {hi,lo} = 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
- DONE: done=1 for one cycle; div_zero=1 only for the zero-divisor case; then IDLE.

Latency and handshake:
- Normal operation: start sampled at edge 0; done high in the cycle after edge WIDTH+2, i.e. WIDTH+2 cycles of busy before done plus the done cycle.
- Divide-by-zero: done and div_zero high in the cycle after edge 0 (busy high for that cycle only). hi/lo are NOT modified.
- start while busy=1 is ignored. No queuing, no abort other than reset.
- hi/lo hold their last values between operations and change only at the FIX edge.

Arithmetic rules:
- Signed division truncates toward zero; the remainder carries the dividend's sign.
- DIV of most-negative by -1 wraps: lo=2^(W-1) pattern, hi=0, no flag.
- Unsigned ops never negate.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state enum IDLE/CALC/FIX/DONE;
  - the package is shared with the control FSM, which drives op.
- One combinational sub-module, mdu_sign_fix: conditional two's-complement negate of a WIDTH-bit value. Instanced for operand abs and for result correction.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done exactly 34 cycles after start edge, single-cycle pulse.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; div_zero stays 0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- Preload hi/lo via MULTU 5*5, then DIV a=9, b=0 -> done and div_zero high one cycle after start; hi=0, lo=25 unchanged.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start MULT, pulse start again at cycle 5 (ignored), drive reset=0 at cycle 10 -> next cycle busy=0, hi=lo=0, no done ever asserted; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit and the control FSM that drives its op input.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, HI/LO result pair.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic                 div_q, div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic [WIDTH-1:0]     abs_a, abs_b, rem_fix;
  logic [2*WIDTH-1:0]   res_fix;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH+1:0]     div_trial;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
    .neg_i(op_is_signed(op) & a[WIDTH-1]),
    .val_i(a),
    .val_o(abs_a)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
    .neg_i(op_is_signed(op) & b[WIDTH-1]),
    .val_i(b),
    .val_o(abs_b)
  );

  // The low half of a 2W negation equals the W-bit negation, so the quotient shares this instance.
  mdu_sign_fix #(.WIDTH(2 * WIDTH)) u_fix_res (
    .neg_i(neg_res_q),
    .val_i(acc_q),
    .val_o(res_fix)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i(neg_rem_q),
    .val_i(rem_q[WIDTH-1:0]),
    .val_o(rem_fix)
  );

  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_trial = {rem_q, acc_q[WIDTH-1]} - {2'b00, opnd_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    div_d      = div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = done_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          div_d  = op_is_div(op);
          if (op_is_div(op) && (b == '0)) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            cnt_d     = CNT_W'(WIDTH);
            rem_d     = '0;
            neg_res_d = op_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = op_is_signed(op) & op_is_div(op) & a[WIDTH-1];
            opnd_d    = op_is_div(op) ? abs_b : abs_a;
            acc_d     = {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (div_q) begin
          // Borrow out means the trial subtraction failed: restore and shift in a zero.
          rem_d = div_trial[WIDTH+1] ? {rem_q[WIDTH-1:0], acc_q[WIDTH-1]} : div_trial[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        if (div_q) begin
          lo_d = res_fix[WIDTH-1:0];
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = res_fix;
        end
        state_d = DONE;
      end
      DONE: begin
        // Divide-by-zero enters with the pulse already raised; the normal path raises it here.
        if (done_q) begin
          done_d     = 1'b0;
          div_zero_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      div_q      <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Table-driven bench for mult_div_unit with a done-triggered scoreboard and reset-abort sequence.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_hi", 64'(hi), 64'(e.hi));
        check("sb_lo", 64'(lo), 64'(e.lo));
        check("sb_div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input exp_t e, input string tag);
    int cycles;
    int exp_lat;
    exp_lat = e.dz ? 0 : W + 2;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, 64'(done), 64'd1);
      sb_q.delete();
    end else begin
      check({tag, "_latency"}, 64'(cycles - 1), 64'(exp_lat));
      check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    exp_t e;
    int done_seen;

    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{2'b01, 32'd5,        32'd5,        32'd0,        32'd25,       1'b0};
    vecs[5]  = '{2'b10, 32'd9,        32'd0,        32'd0,        32'd25,       1'b1};
    vecs[6]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{2'b11, 32'd7,        32'd0,        32'h00000000, 32'h80000000, 1'b1};
    vecs[8]  = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
    vecs[9]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{2'b00, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
    vecs[12] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};

    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      e = '{vecs[i].hi, vecs[i].lo, vecs[i].dz};
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
    end

    // Abort: second start while busy is ignored, reset mid-operation clears everything.
    @(negedge clk);
    op = 2'b00; a = 32'd1234; b = 32'd5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_mid", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    done_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);

    e = '{32'd0, 32'd42, 1'b0};
    run_op(2'b01, 32'd6, 32'd7, e, "post_reset");

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
